// File: rtl/rc_offset_sched.sv
// Per-slice rate-control offset scheduler: counts decoded blocks, ramps the
// initial RC offset down over the delay window and the fullness offset up past Th.
module rc_offset_sched #(
  parameter int          AVE_BLK_BITS = 128,
  parameter int          OFFSET_INIT  = 8192,
  parameter logic [23:0] FULL_MAX     = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        slice_start,
  input  logic [11:0] num_blks_in_slice,
  input  logic [7:0]  num_blks_in_line,
  input  logic [7:0]  init_tx_delay,
  input  logic [15:0] offset_thd,
  input  logic [23:0] fullness_slope,
  input  logic        blk_done,
  output logic [15:0] rc_offset_init,
  output logic [23:0] rc_fullness_offset,
  output logic [11:0] blk_idx,
  output logic [1:0]  phase,
  output logic        upd_valid,
  output logic        slice_done
);

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_INIT = 2'd1,
    PH_MID  = 2'd2,
    PH_END  = 2'd3
  } phase_t;

  localparam logic [15:0] AVE16  = AVE_BLK_BITS[15:0];
  localparam logic [15:0] INIT16 = OFFSET_INIT[15:0];

  phase_t      state;
  logic [11:0] cfg_slice;
  logic [7:0]  cfg_delay;
  logic [23:0] cfg_slope;
  logic [11:0] th;

  // Handshake: slice_start and blk_done are single-cycle strobes with no
  // back-pressure; upd_valid/slice_done are single-cycle strobes one clock later.
  logic [23:0] thd_prod;
  logic [11:0] th_start;
  phase_t      phase_start;

  assign thd_prod = {16'd0, num_blks_in_line} * {8'd0, offset_thd};
  assign th_start = (thd_prod >= {12'd0, num_blks_in_slice}) ? 12'd0
                                                           : num_blks_in_slice - thd_prod[11:0];
  assign phase_start = (init_tx_delay != 8'd0) ? PH_INIT :
                       (th_start == 12'd0)     ? PH_END  : PH_MID;

  logic [11:0] idx_next;
  logic        in_delay;
  logic        in_end;
  logic [15:0] offset_dec;
  logic [24:0] full_sum;
  logic [23:0] full_sat;
  phase_t      phase_blk;

  assign idx_next   = blk_idx + 12'd1;
  assign in_delay   = blk_idx < {4'd0, cfg_delay};
  assign in_end     = blk_idx >= th;
  assign offset_dec = (rc_offset_init >= AVE16) ? rc_offset_init - AVE16 : 16'd0;
  assign full_sum   = {1'b0, rc_fullness_offset} + {1'b0, cfg_slope};
  assign full_sat   = (full_sum > {1'b0, FULL_MAX}) ? FULL_MAX : full_sum[23:0];

  // Phase evaluated against the post-increment block count.
  always_comb begin
    phase_blk = state;
    if (idx_next == cfg_slice) begin
      phase_blk = PH_IDLE;
    end else begin
      case (state)
        PH_INIT: begin
          if (idx_next >= {4'd0, cfg_delay} && idx_next >= th)      phase_blk = PH_END;
          else if (idx_next == {4'd0, cfg_delay} && idx_next < th) phase_blk = PH_MID;
        end
        PH_MID:  if (idx_next >= th) phase_blk = PH_END;
        default: phase_blk = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state              <= PH_IDLE;
      cfg_slice          <= 12'd0;
      cfg_delay          <= 8'd0;
      cfg_slope          <= 24'd0;
      th                 <= 12'd0;
      blk_idx            <= 12'd0;
      rc_offset_init     <= INIT16;
      rc_fullness_offset <= 24'd0;
      upd_valid          <= 1'b0;
      slice_done         <= 1'b0;
    end else begin
      upd_valid  <= 1'b0;
      slice_done <= 1'b0;
      if (slice_start) begin
        cfg_slice          <= num_blks_in_slice;
        cfg_delay          <= init_tx_delay;
        cfg_slope          <= fullness_slope;
        th                 <= th_start;
        blk_idx            <= 12'd0;
        rc_offset_init     <= INIT16;
        rc_fullness_offset <= 24'd0;
        // An empty slice finishes immediately without any block update.
        if (num_blks_in_slice == 12'd0) begin
          state      <= PH_IDLE;
          slice_done <= 1'b1;
        end else begin
          state <= phase_start;
        end
      end else if (blk_done && state != PH_IDLE) begin
        if (in_delay) rc_offset_init     <= offset_dec;
        if (in_end)   rc_fullness_offset <= full_sat;
        blk_idx    <= idx_next;
        state      <= phase_blk;
        upd_valid  <= 1'b1;
        slice_done <= (idx_next == cfg_slice);
      end
    end
  end

  assign phase = state;

endmodule
